// File: rtl/multiword_addsub_if.sv
// Handshake and operand/result bundle for the multi-word adder/subtractor.
// The master drives the request side; the slave (the engine) drives status and results.
interface multiword_addsub_if #(
    parameter int WIDTH = 8,
    parameter int WORDS = 2
) ();
    logic                     start;
    logic [2:0]               sign;
    logic [WIDTH*WORDS-1:0]   a;
    logic [WIDTH*WORDS-1:0]   b;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [WIDTH*WORDS-1:0]   result;
    logic                     carry_out;
    logic                     led2;
    logic                     zero;
    logic                     ovf;

    modport master (
        output start, sign, a, b,
        input  busy, done, err, result, carry_out, led2, zero, ovf
    );

    modport slave (
        input  start, sign, a, b,
        output busy, done, err, result, carry_out, led2, zero, ovf
    );
endinterface

// File: rtl/multiword_addsub.sv
// Multi-precision adder/subtractor: one WIDTH-bit slice per clock, LSW first,
// linked by a carry register; flags are published in a single DONE cycle.
module multiword_addsub #(
    parameter int WIDTH  = 8,
    parameter int WORDS  = 2,
    parameter int OP_ADD = 3,
    parameter int OP_SUB = 4
) (
    input  logic               clk,
    input  logic               rst,
    multiword_addsub_if.slave  bus
);
    localparam int N     = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               sub_q;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic [N-1:0]       result_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               carry_out_q;
    logic               led2_q;
    logic               zero_q;
    logic               ovf_q;

    int                 base;
    logic [WIDTH:0]     slice_sum;

    // b_q already holds ~B for subtraction, so every slice is a plain add with carry.
    always_comb begin
        base      = int'(idx) * WIDTH;
        slice_sum = {1'b0, a_q[base +: WIDTH]} + {1'b0, b_q[base +: WIDTH]}
                  + {{WIDTH{1'b0}}, carry};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            sub_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            carry_out_q <= 1'b0;
            led2_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.sign == 3'(OP_ADD) || bus.sign == 3'(OP_SUB)) begin
                            sub_q  <= (bus.sign == 3'(OP_SUB));
                            a_q    <= bus.a;
                            b_q    <= (bus.sign == 3'(OP_SUB)) ? ~bus.b : bus.b;
                            carry  <= (bus.sign == 3'(OP_SUB));
                            idx    <= '0;
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    result_q[base +: WIDTH] <= slice_sum[WIDTH-1:0];
                    carry <= slice_sum[WIDTH];
                    idx   <= idx + 1'b1;
                    if (idx == IDX_W'(WORDS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Sign of B' is b_q's MSB, since b_q was stored pre-inverted for SUB.
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    carry_out_q <= carry;
                    led2_q      <= sub_q ? ~carry : carry;
                    zero_q      <= (result_q == '0);
                    ovf_q       <= (a_q[N-1] == b_q[N-1]) && (result_q[N-1] != a_q[N-1]);
                    state       <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.led2      = led2_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multiword_addsub.sv
// Bench for multiword_addsub (WIDTH=8, WORDS=2): directed vectors with literal
// expectations plus a per-cycle compare against an arithmetic reference model.
module tb_multiword_addsub;
    localparam int WIDTH  = 8;
    localparam int WORDS  = 2;
    localparam int N      = WIDTH * WORDS;
    localparam int OP_ADD = 3;
    localparam int OP_SUB = 4;

    logic clk;
    logic rst;
    int   vec_count;
    int   miscompares;

    multiword_addsub_if #(.WIDTH(WIDTH), .WORDS(WORDS)) bus ();

    multiword_addsub #(
        .WIDTH(WIDTH), .WORDS(WORDS), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, updated on each rising edge from the sampled request.
    int           cyc;
    int           free_cyc;
    int           acc_cyc;
    int           done_cyc;
    int           err_cyc;
    logic         exp_busy, exp_done, exp_err;
    logic [N-1:0] exp_result, pend_result;
    logic         exp_carry, exp_led2, exp_zero, exp_ovf;
    logic         pend_carry, pend_led2, pend_zero, pend_ovf;
    logic         check_en;

    task automatic model_reset();
        free_cyc   = 0;
        acc_cyc    = -100;
        done_cyc   = -100;
        err_cyc    = -100;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        exp_result = '0;
        exp_carry  = 1'b0;
        exp_led2   = 1'b0;
        exp_zero   = 1'b0;
        exp_ovf    = 1'b0;
    endtask

    // Results from the textbook definitions: unsigned carry/no-borrow and signed range.
    task automatic model_compute(input logic is_sub, input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb, sr;
        logic [N:0] full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_sub) begin
            full       = {1'b0, a} - {1'b0, b};
            pend_carry = (a >= b);
            sr         = sa - sb;
        end else begin
            full       = {1'b0, a} + {1'b0, b};
            pend_carry = full[N];
            sr         = sa + sb;
        end
        pend_result = full[N-1:0];
        pend_led2   = is_sub ? ~pend_carry : pend_carry;
        pend_zero   = (pend_result == '0);
        pend_ovf    = (sr > ((64'sd1 <<< (N - 1)) - 1)) || (sr < -(64'sd1 <<< (N - 1)));
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                cyc = cyc + 1;
                if (cyc == done_cyc) begin
                    exp_result = pend_result;
                    exp_carry  = pend_carry;
                    exp_led2   = pend_led2;
                    exp_zero   = pend_zero;
                    exp_ovf    = pend_ovf;
                end
                if (bus.start && cyc >= free_cyc) begin
                    if (bus.sign == 3'(OP_ADD) || bus.sign == 3'(OP_SUB)) begin
                        model_compute(bus.sign == 3'(OP_SUB), bus.a, bus.b);
                        acc_cyc  = cyc;
                        done_cyc = cyc + WORDS + 1;
                        free_cyc = cyc + WORDS + 2;
                    end else begin
                        err_cyc = cyc;
                    end
                end
                exp_done = (cyc == done_cyc);
                exp_err  = (cyc == err_cyc);
                exp_busy = (cyc >= acc_cyc) && (cyc <= acc_cyc + WORDS);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_count = vec_count + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison; result is only meaningful outside busy since slices land one at a time.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                checkOutput("busy",      64'(bus.busy),      64'(exp_busy));
                checkOutput("done",      64'(bus.done),      64'(exp_done));
                checkOutput("err",       64'(bus.err),       64'(exp_err));
                checkOutput("carry_out", 64'(bus.carry_out), 64'(exp_carry));
                checkOutput("led2",      64'(bus.led2),      64'(exp_led2));
                checkOutput("zero",      64'(bus.zero),      64'(exp_zero));
                checkOutput("ovf",       64'(bus.ovf),       64'(exp_ovf));
                if (!exp_busy) begin
                    checkOutput("result", 64'(bus.result), 64'(exp_result));
                end
            end
        end
    end

    // One-cycle start pulse; returns at the falling edge after the sampling edge.
    task automatic applyStimulus(input logic [2:0] sign, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sign  = sign;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [2:0]   sign;
        logic [N-1:0] a, b, res;
        logic         c, l, z, o;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout reached at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int lat;
        int ndone;
        int last_done;
        vec_count   = 0;
        miscompares = 0;
        check_en    = 1'b0;
        bus.start   = 1'b0;
        bus.sign    = 3'd0;
        bus.a       = '0;
        bus.b       = '0;
        rst         = 1'b1;

        vecs[0] = '{3'(OP_ADD), 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'(OP_ADD), 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{3'(OP_SUB), 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{3'(OP_SUB), 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{3'(OP_ADD), 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{3'(OP_SUB), 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{3'(OP_ADD), 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{3'(OP_SUB), 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("reset_busy",   64'(bus.busy),   64'd0);
        checkOutput("reset_done",   64'(bus.done),   64'd0);
        checkOutput("reset_result", 64'(bus.result), 64'd0);
        checkOutput("reset_ovf",    64'(bus.ovf),    64'd0);
        rst = 1'b0;
        check_en = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sign, vecs[i].a, vecs[i].b);
            wait_done(lat);
            checkOutput("latency",       64'(lat),           64'(WORDS + 1));
            checkOutput("lit_result",    64'(bus.result),    64'(vecs[i].res));
            checkOutput("lit_carry_out", 64'(bus.carry_out), 64'(vecs[i].c));
            checkOutput("lit_led2",      64'(bus.led2),      64'(vecs[i].l));
            checkOutput("lit_zero",      64'(bus.zero),      64'(vecs[i].z));
            checkOutput("lit_ovf",       64'(bus.ovf),       64'(vecs[i].o));
        end

        // Illegal sign: one err pulse, nothing else moves.
        applyStimulus(3'd2, 16'hAAAA, 16'h5555);
        checkOutput("err_pulse",      64'(bus.err),    64'd1);
        checkOutput("err_busy",       64'(bus.busy),   64'd0);
        @(negedge clk);
        checkOutput("err_cleared",    64'(bus.err),    64'd0);
        checkOutput("err_result_held", 64'(bus.result), 64'hFFFF);

        // Start pulsed while busy must be ignored.
        applyStimulus(3'(OP_ADD), 16'h0001, 16'h0002);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sign  = 3'(OP_SUB);
        bus.a     = 16'h4444;
        bus.b     = 16'h0004;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        checkOutput("busy_start_dones",  64'(ndone),      64'd1);
        checkOutput("busy_start_result", 64'(bus.result), 64'h0003);

        // Asynchronous reset after slice 0 has been processed.
        applyStimulus(3'(OP_ADD), 16'hFFFF, 16'hFFFF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy",   64'(bus.busy),   64'd0);
        checkOutput("midrst_result", 64'(bus.result), 64'd0);
        checkOutput("midrst_zero",   64'(bus.zero),   64'd0);
        checkOutput("midrst_carry",  64'(bus.carry_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(3'(OP_ADD), 16'h1234, 16'h1111);
        wait_done(lat);
        checkOutput("post_rst_result", 64'(bus.result), 64'h2345);

        // start held high: a new op every WORDS+2 cycles, varying operands each cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.sign  = 3'(OP_ADD);
        ndone     = 0;
        last_done = -1;
        for (int i = 0; i < 17; i++) begin
            bus.a = 16'(16'h0101 * i + 16'h00F0);
            bus.b = 16'(16'h0F0F + i);
            @(negedge clk);
            if (bus.done) begin
                if (last_done >= 0) checkOutput("b2b_spacing", 64'(i - last_done), 64'(WORDS + 2));
                last_done = i;
                ndone++;
            end
        end
        bus.start = 1'b0;
        checkOutput("b2b_done_count", 64'(ndone), 64'd4);
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
